serial_deser: RTL and testbench
===============================

Name: serial_deser

Overview:
- Downstream consumer of the team's serial bit stream: accepts one bit per strobe, LSB first, and assembles WIDTH-bit words.
- Presents each completed word on a single-entry valid/ready output holding register.
- Detects overrun when the holding register is still occupied at word completion.
- Sits between the serial shifter output (q, qualified by its shift strobe) and the parallel datapath.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data bit, LSB of word first.
- ser_valid  input  1  bit strobe; ser_in sampled only when 1.
- sof  input  1  start of frame; qualified by ser_valid; marks the accompanying bit as bit 0.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
- out_perr  output  1  parity error for the word in out_data; constant 0 without PARITY_EN.
- overrun  output  1  sticky; a completed word was dropped.
- clr_overrun  input  1  clears overrun.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_perr=0, overrun=0, bit counter=0, assembly register=0.
- Reset mid-word discards all partial data.
- Assembly:
  - On ser_valid, ser_in is written into assembly bit [bit_cnt] and bit_cnt increments.
  - ser_valid=0 holds all state; gaps of any length are legal.
- sof:
  - ser_valid & sof forces this bit into position 0 and sets bit_cnt to 1.
  - Any partial word is silently discarded.
  - sof without ser_valid is ignored.
- Word completion: the strobe that writes the last bit (bit_cnt==WIDTH-1, or the parity bit with PARITY_EN) completes the word.
  - bit_cnt wraps to 0.
- Latency: out_valid rises on the clock edge that samples the completing bit, so it is visible the cycle after that strobe.
- Holding register load rules at completion:
  - If out_valid=0, or out_valid & out_ready in the same cycle: load the word; out_valid is 1 next cycle. Back-to-back completion and consumption never drops a word.
  - If out_valid=1 & out_ready=0: the new word is dropped, the held word is unchanged, and overrun sets.
- Handshake:
  - out_data and out_perr are stable while out_valid=1 & out_ready=0.
  - out_valid clears after a transfer unless a new word loads in the same cycle.
  - out_ready is ignored when out_valid=0.
- Overrun:
  - Sticky until clr_overrun.
  - If clr_overrun and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- No combinational path from inputs to outputs; all outputs are registered.
- Assembly continues while the holding register is full.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; bit_cnt counts 0..WIDTH.
  - out_perr is loaded together with out_data and is 1 when the XOR of data bits and parity bit is 1.
  - A dropped word (overrun) does not affect out_perr.
- Undefined:
  - Frame is WIDTH bits and bit_cnt counts 0..WIDTH-1.
  - out_perr port still exists, tied to 0.

Decomposition:
- Package serial_pkg holds:
  - DEFAULT_WIDTH = 8.
  - A function for the bit-counter width, $clog2(WIDTH+1).
  - Even-parity helper function.
  - Shared with other serial-path blocks.
- No sub-module; the counter, assembly register and holding register are a single flat module.

Test Plan:
- Basic word: WIDTH=8, out_ready=1; stream 0xA5 LSB first (1,0,1,0,0,1,0,1), ser_valid every cycle, sof on the first bit -> out_data=0xA5 and out_valid=1 for exactly one cycle, the cycle after the 8th strobe; overrun=0.
- Gapped strobes: same 0xA5 with ser_valid asserted every 3rd cycle -> identical result; no state change on idle cycles.
- Backpressure/overrun: out_ready=0; send 0x3C then 0xF0 -> out_data=0x3C held, overrun=1 after the 0xF0 completes. Then raise out_ready for one cycle -> 0x3C transferred, out_valid=0, overrun still 1. Pulse clr_overrun -> overrun=0.
- Same-cycle transfer: hold 0x11 with out_ready=0; raise out_ready exactly on the cycle 0x22 completes -> 0x11 transfers, out_data=0x22 next cycle, out_valid stays 1, overrun=0.
- Resync and reset: 3 bits sent, then sof with 0x81 -> out_data=0x81. Separately, rst after 4 bits, then a full 0x55 -> out_data=0x55; out_valid=0 throughout reset.
- Parity (SERIAL_DESER_PARITY_EN): 0xA5 with parity bit 0 -> out_perr=0. 0xA5 with parity bit 1 -> out_perr=1. Word completes after the 9th strobe.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial-path blocks: the default word width,
// the bit-counter width helper and the even-parity helper.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed for a counter that must reach WIDTH, which is the parity-bit slot.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Even-parity bit over a word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/serial_deser.sv
// serial_deser: assembles an LSB-first serial bit stream into WIDTH-bit words.
// Each word is presented on a single-entry valid/ready holding register.
// A word that completes while the register is still occupied is dropped,
// and the sticky overrun flag records the loss.
// Optional build macro SERIAL_DESER_PARITY_EN: every frame carries one
// trailing even-parity bit, and out_perr flags a parity mismatch.
module serial_deser
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int CW = cnt_width(WIDTH);

`ifdef SERIAL_DESER_PARITY_EN
  // Parity builds: the last strobe of a frame carries the parity bit.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`endif

  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [WIDTH-1:0] asm_q,      asm_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_perr_q, out_perr_d;
  logic             overrun_q,  overrun_d;

  logic [CW-1:0]    pos_s;
  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic             perr_new_s;
  logic             load_s;
  logic             drop_s;

  // Next-state logic: bit placement, word completion, holding register and overrun.
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_perr_d  = out_perr_q;
    overrun_d   = overrun_q;

    // A strobe with sof restarts the frame at bit 0 and discards any partial word.
    pos_s  = sof ? {CW{1'b0}} : cnt_q;
    word_s = sof ? {WIDTH{1'b0}} : asm_q;
    for (int i = 0; i < WIDTH; i++) begin
      word_s[i] = (pos_s == CW'(i)) ? ser_in : word_s[i];
    end

    complete_s = ser_valid && (pos_s == LAST_IDX);

`ifdef SERIAL_DESER_PARITY_EN
    // The parity bit is never written into word_s, so word_s holds only data bits here.
    perr_new_s = even_parity(32'(word_s)) ^ ser_in;
`else
    perr_new_s = 1'b0;
`endif

    // The holding register is free when empty or when it is being drained this cycle.
    load_s = complete_s && (!out_valid_q || out_ready);
    drop_s = complete_s && out_valid_q && !out_ready;

    if (ser_valid) begin
      if (complete_s) begin
        cnt_d = {CW{1'b0}};
        asm_d = {WIDTH{1'b0}};
      end else begin
        cnt_d = pos_s + CW'(1);
        asm_d = word_s;
      end
    end else begin
      cnt_d = cnt_q;
      asm_d = asm_q;
    end

    if (load_s) begin
      out_data_d  = word_s;
      out_perr_d  = perr_new_s;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // If a drop and a clear arrive together, the drop wins so the loss is not hidden.
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers with synchronous reset; a reset mid-word discards the partial data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= {CW{1'b0}};
      asm_q       <= {WIDTH{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_perr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_perr_q  <= out_perr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_perr  = out_perr_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: directed steps followed by a
// randomized stream checked against a word-level reference model.
module tb_serial_deser;

  localparam int W = 8;
`ifdef SERIAL_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         sof = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_perr;
  logic         overrun;
  logic         clr_overrun = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  serial_deser #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .sof         (sof),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_perr    (out_perr),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    ser_in    = b;
    sof       = s;
    ser_valid = 1'b1;
    tick();
    ser_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Sends one frame LSB first with sof on bit 0; gap idle cycles follow each
  // non-final strobe; ready_last raises out_ready on the completing strobe.
  task automatic send_word(input logic [W-1:0] w, input logic pbit,
                           input int gap, input logic ready_last);
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 1 && ready_last) out_ready = 1'b1;
      send_bit((i < W) ? w[i] : pbit, (i == 0));
      if (i != FRAME - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check("gap_valid_idle", out_valid, 1'b0);
        end
      end
    end
  endtask

  // Randomized-run reference state: the held word and the sticky flag.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_perr;
  logic         m_ovr;
  logic [W-1:0] r_word;
  logic         r_pbit;
  int           r_k;

  initial begin
    logic [W-1:0] a5;
    a5 = 8'hA5;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_perr", out_perr, 1'b0);
    rst = 1'b0;
    tick();

    // Basic word, strobe every cycle, consumer always ready.
    out_ready = 1'b1;
    send_word(8'hA5, 1'b0, 0, 1'b0);
    check("basic_valid", out_valid, 1'b1);
    check("basic_data", out_data, 8'hA5);
    check("basic_overrun", overrun, 1'b0);
    tick();
    check("basic_valid_one_cycle", out_valid, 1'b0);

    // Same word with ser_valid every third cycle.
    send_word(8'hA5, 1'b0, 2, 1'b0);
    check("gap_valid", out_valid, 1'b1);
    check("gap_data", out_data, 8'hA5);
    tick();
    check("gap_valid_one_cycle", out_valid, 1'b0);

    // Backpressure and overrun.
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0, 0, 1'b0);
    check("bp_first_valid", out_valid, 1'b1);
    check("bp_first_data", out_data, 8'h3C);
    send_word(8'hF0, 1'b0, 0, 1'b0);
    check("bp_held_data", out_data, 8'h3C);
    check("bp_held_valid", out_valid, 1'b1);
    check("bp_overrun_set", overrun, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_drained", out_valid, 1'b0);
    check("bp_overrun_sticky", overrun, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("bp_overrun_clear", overrun, 1'b0);

    // Transfer and load on the same edge.
    send_word(8'h11, 1'b0, 0, 1'b0);
    check("same_hold_data", out_data, 8'h11);
    tick();
    check("same_hold_stable", out_data, 8'h11);
    send_word(8'h22, 1'b0, 0, 1'b1);
    check("same_new_data", out_data, 8'h22);
    check("same_new_valid", out_valid, 1'b1);
    check("same_no_overrun", overrun, 1'b0);
    tick();
    check("same_drained", out_valid, 1'b0);

    // Resync: three stray bits, then a fresh frame with sof.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    send_word(8'h81, 1'b1, 0, 1'b0);
    check("resync_data", out_data, 8'h81);
    check("resync_valid", out_valid, 1'b1);
    tick();

    // Reset mid-word, then a full word sent without sof.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 8'h00);
    tick();
    check("midrst_valid2", out_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      logic [W-1:0] v;
      v = 8'h55;
      send_bit((i < W) ? v[i] : 1'b0, 1'b0);
    end
    check("midrst_word_data", out_data, 8'h55);
    check("midrst_word_valid", out_valid, 1'b1);
    tick();

`ifdef SERIAL_DESER_PARITY_EN
    // Parity: 0xA5 has even weight, so parity bit 0 is correct and 1 is an error.
    for (int i = 0; i < W; i++) send_bit(a5[i], (i == 0));
    check("par_not_done_after_data", out_valid, 1'b0);
    send_bit(1'b0, 1'b0);
    check("par_ok_valid", out_valid, 1'b1);
    check("par_ok_perr", out_perr, 1'b0);
    tick();
    send_word(8'hA5, 1'b1, 0, 1'b0);
    check("par_bad_data", out_data, 8'hA5);
    check("par_bad_perr", out_perr, 1'b1);
    tick();
`else
    check("noparity_perr", out_perr, 1'b0);
    check("noparity_a5_bit0", a5[0], 1'b1);
`endif

    // Randomized stream against a word-level model of the holding register.
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_perr  = 1'b0;
    m_ovr   = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_k    = 0;
    r_word = W'($urandom);
    r_pbit = 1'($urandom);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic strobe, rdy, clr, done, setov;
      logic [W-1:0] w_now;
      logic p_now;
      strobe = ($urandom_range(0, 2) != 0);
      rdy    = ($urandom_range(0, 3) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      // Occasionally abandon the current frame and restart with sof.
      if (strobe && r_k > 0 && $urandom_range(0, 24) == 0) begin
        r_k    = 0;
        r_word = W'($urandom);
        r_pbit = 1'($urandom);
      end
      ser_valid   = strobe;
      sof         = strobe && (r_k == 0);
      ser_in      = (r_k < W) ? r_word[r_k] : r_pbit;
      out_ready   = rdy;
      clr_overrun = clr;
      done  = strobe && (r_k == FRAME - 1);
      w_now = r_word;
`ifdef SERIAL_DESER_PARITY_EN
      p_now = (^r_word) ^ r_pbit;
`else
      p_now = 1'b0;
`endif
      tick();
      setov = 1'b0;
      if (done && (!m_valid || rdy)) begin
        m_data  = w_now;
        m_perr  = p_now;
        m_valid = 1'b1;
      end else if (done) begin
        setov = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (setov) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (strobe) begin
        if (done) begin
          r_k    = 0;
          r_word = W'($urandom);
          r_pbit = 1'($urandom);
        end else begin
          r_k++;
        end
      end
      check("rand_valid", out_valid, m_valid);
      check("rand_overrun", overrun, m_ovr);
      if (m_valid) begin
        check("rand_data", out_data, m_data);
        check("rand_perr", out_perr, m_perr);
      end
    end
    ser_valid   = 1'b0;
    sof         = 1'b0;
    clr_overrun = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
